// File: rtl/hit_min_reduce.sv
// Drains per-triangle Q16.16 hit distances from a FWFT FIFO and emits, per ray of
// NUM_TRI samples, the nearest hit t >= EPS with its triangle index into a downstream FIFO.
module hit_min_reduce #(
  parameter int unsigned Q_BITS  = 16,
  parameter int unsigned NUM_TRI = 4,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned RAY_W   = 16,
  parameter int          EPS     = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      in_dout,
  input  logic             in_empty,
  output logic             in_rd_en,
  output logic [31:0]      out_t,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_hit,
  output logic [RAY_W-1:0] out_ray,
  output logic             out_wr_en,
  input  logic             out_full
);

  localparam logic [31:0]      T_MISS   = 32'h7FFF_FFFF;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRI - 1);

  // EPS is in raw LSBs of a Q_BITS-fraction value; reject nonsensical configurations early.
  if (NUM_TRI < 1 || 64'(NUM_TRI) > (64'(1) << IDX_W) || Q_BITS > 31) begin : g_bad_params
    $error("hit_min_reduce: illegal NUM_TRI/IDX_W/Q_BITS combination");
  end

  typedef enum logic {S_ACC, S_EMIT} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             have_hit, have_hit_nxt;
  logic [31:0]      best_t, best_t_nxt;
  logic [IDX_W-1:0] best_idx, best_idx_nxt;
  logic [RAY_W-1:0] ray_cnt, ray_cnt_nxt;
  logic [31:0]      out_t_nxt;
  logic [IDX_W-1:0] out_idx_nxt;
  logic             out_hit_nxt;
  logic [RAY_W-1:0] out_ray_nxt;
  logic             sample_valid;
  logic             sample_better;

  assign sample_valid  = $signed(in_dout) >= EPS;
  assign sample_better = !have_hit || ($signed(in_dout) < $signed(best_t));

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_ACC;
      cnt      <= '0;
      have_hit <= 1'b0;
      best_t   <= T_MISS;
      best_idx <= '0;
      ray_cnt  <= '0;
      out_t    <= '0;
      out_idx  <= '0;
      out_hit  <= 1'b0;
      out_ray  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      have_hit <= have_hit_nxt;
      best_t   <= best_t_nxt;
      best_idx <= best_idx_nxt;
      ray_cnt  <= ray_cnt_nxt;
      out_t    <= out_t_nxt;
      out_idx  <= out_idx_nxt;
      out_hit  <= out_hit_nxt;
      out_ray  <= out_ray_nxt;
    end
  end

  // Next-state, accumulation and FIFO handshakes
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    have_hit_nxt = have_hit;
    best_t_nxt   = best_t;
    best_idx_nxt = best_idx;
    ray_cnt_nxt  = ray_cnt;
    out_t_nxt    = out_t;
    out_idx_nxt  = out_idx;
    out_hit_nxt  = out_hit;
    out_ray_nxt  = out_ray;
    in_rd_en     = 1'b0;
    out_wr_en    = 1'b0;

    case (state)
      S_ACC: begin
        in_rd_en = !in_empty;
        if (!in_empty) begin
          if (sample_valid && sample_better) begin
            best_t_nxt   = in_dout;
            best_idx_nxt = cnt;
            have_hit_nxt = 1'b1;
          end
          // Result words are latched here so they already include the final sample.
          if (cnt == LAST_IDX) begin
            cnt_nxt     = '0;
            state_nxt   = S_EMIT;
            out_hit_nxt = have_hit_nxt;
            out_t_nxt   = have_hit_nxt ? best_t_nxt : T_MISS;
            out_idx_nxt = have_hit_nxt ? best_idx_nxt : '0;
            out_ray_nxt = ray_cnt;
          end else begin
            cnt_nxt = cnt + IDX_W'(1);
          end
        end
      end
      S_EMIT: begin
        out_wr_en = !out_full;
        if (!out_full) begin
          ray_cnt_nxt  = ray_cnt + RAY_W'(1);
          have_hit_nxt = 1'b0;
          best_t_nxt   = T_MISS;
          best_idx_nxt = '0;
          state_nxt    = S_ACC;
        end
      end
      default: state_nxt = S_ACC;
    endcase

    if (reset) begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_hit_min_reduce.sv
// Directed bench for hit_min_reduce: FWFT source model, write monitor, vector table
// plus hand-written backpressure, gap, reset, wrap and NUM_TRI=1 sequences.
module tb_hit_min_reduce;

  logic        clock;
  logic        reset;
  logic [31:0] in_dout;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] out_t;
  logic [7:0]  out_idx;
  logic        out_hit;
  logic [3:0]  out_ray;
  logic        out_wr_en;
  logic        out_full;

  logic [31:0] in_dout1;
  logic        in_empty1;
  logic        in_rd_en1;
  logic [31:0] out_t1;
  logic [7:0]  out_idx1;
  logic        out_hit1;
  logic [15:0] out_ray1;
  logic        out_wr_en1;

  hit_min_reduce #(.NUM_TRI(4), .IDX_W(8), .RAY_W(4)) dut (
    .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out_t(out_t), .out_idx(out_idx), .out_hit(out_hit),
    .out_ray(out_ray), .out_wr_en(out_wr_en), .out_full(out_full)
  );

  hit_min_reduce #(.NUM_TRI(1), .IDX_W(8), .RAY_W(16)) dut1 (
    .clock(clock), .reset(reset), .in_dout(in_dout1), .in_empty(in_empty1),
    .in_rd_en(in_rd_en1), .out_t(out_t1), .out_idx(out_idx1), .out_hit(out_hit1),
    .out_ray(out_ray1), .out_wr_en(out_wr_en1), .out_full(1'b0)
  );

  typedef struct {
    logic [0:3][31:0] s;
    logic [31:0]      t;
    logic [7:0]       idx;
    logic             hit;
  } vec_t;

  typedef struct {
    logic [31:0] t;
    logic [7:0]  idx;
    logic        hit;
    logic [3:0]  ray;
    int          lat;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_pop = -1000;
  int          viol = 0;
  int          n_wr = 0;
  int          exp_wr = 0;
  int          gap = 0;
  int          gap_left = 0;
  bit          pop_now = 0;
  logic [31:0] sq[$];
  wr_t         wq[$];

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // FWFT source: pops the head after a sampled pop, optionally inserting empty gaps
  always @(posedge clock) begin
    cyc++;
    #1;
    if (pop_now) begin
      void'(sq.pop_front());
      gap_left = gap;
    end else if (gap_left > 0) begin
      gap_left--;
    end
    in_empty = (sq.size() == 0) || (gap_left > 0);
    in_dout  = (sq.size() != 0) ? sq[0] : 32'h0;
  end

  // Handshake monitor, sampled mid-cycle
  always @(negedge clock) begin
    wr_t w;
    if (in_rd_en && in_empty) viol++;
    if (out_wr_en && out_full) viol++;
    if (out_wr_en) begin
      w.t = out_t; w.idx = out_idx; w.hit = out_hit; w.ray = out_ray;
      w.lat = cyc - last_pop;
      wq.push_back(w);
      n_wr++;
    end
    pop_now = in_rd_en && !in_empty;
    if (pop_now) last_pop = cyc;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [0:3][31:0] s);
    for (int k = 0; k < 4; k++) sq.push_back(s[k]);
  endtask

  task automatic cyc_step();
    @(posedge clock);
    #2;
  endtask

  task automatic get_wr(input string name, output wr_t w);
    int n = 0;
    while (wq.size() == 0 && n < 300) begin
      cyc_step();
      n++;
    end
    exp_wr++;
    checks++;
    if (wq.size() == 0) begin
      failures++;
      $display("FAIL %s_timeout: got no write expected one within 300 cycles", name);
      w.t = 'x; w.idx = 'x; w.hit = 1'bx; w.ray = 'x; w.lat = -1;
    end else begin
      w = wq.pop_front();
    end
  endtask

  vec_t        vec[6];
  wr_t         w;
  logic [3:0]  exp_ray;
  logic [0:3][31:0] partial;

  initial begin
    vec[0] = '{s: '{32'h0003_0000, 32'h0001_8000, 32'hFFFF_0000, 32'h0002_0000}, t: 32'h0001_8000, idx: 8'd1, hit: 1'b1};
    vec[1] = '{s: '{32'h0000_0000, 32'hFFFE_0000, 32'h8000_0000, 32'h0000_0000}, t: 32'h7FFF_FFFF, idx: 8'd0, hit: 1'b0};
    vec[2] = '{s: '{32'h0005_0000, 32'h0002_0000, 32'h0004_0000, 32'h0002_0000}, t: 32'h0002_0000, idx: 8'd1, hit: 1'b1};
    vec[3] = '{s: '{32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000}, t: 32'h7FFF_FFFF, idx: 8'd0, hit: 1'b1};
    vec[4] = '{s: '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001}, t: 32'h0000_0001, idx: 8'd3, hit: 1'b1};
    vec[5] = '{s: '{32'hFFFF_FFFB, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000}, t: 32'h0000_8000, idx: 8'd2, hit: 1'b1};

    reset = 1; out_full = 0; in_empty = 1; in_dout = 0; in_empty1 = 1; in_dout1 = 0;
    repeat (2) cyc_step();
    chk("rst_out_t", out_t, 32'h0);
    chk("rst_out_idx", 32'(out_idx), 32'h0);
    chk("rst_out_hit", 32'(out_hit), 32'h0);
    chk("rst_out_ray", 32'(out_ray), 32'h0);

    // data is available while reset is still high: no pop, no write
    push(vec[0].s);
    cyc_step();
    chk("rst_rd_en", 32'(in_rd_en), 32'h0);
    chk("rst_wr_en", 32'(out_wr_en), 32'h0);
    reset = 0;
    exp_ray = 0;

    for (int i = 0; i < 6; i++) begin
      if (i > 0) push(vec[i].s);
      get_wr($sformatf("vec%0d", i), w);
      chk($sformatf("vec%0d_t", i), w.t, vec[i].t);
      chk($sformatf("vec%0d_idx", i), 32'(w.idx), 32'(vec[i].idx));
      chk($sformatf("vec%0d_hit", i), 32'(w.hit), 32'(vec[i].hit));
      chk($sformatf("vec%0d_ray", i), 32'(w.ray), 32'(exp_ray));
      chk($sformatf("vec%0d_latency", i), 32'(w.lat), 32'd1);
      exp_ray++;
    end

    // backpressure while the next ray is already queued
    out_full = 1;
    push(vec[0].s);
    push(vec[0].s);
    for (int n = 0; n < 100 && sq.size() > 4; n++) cyc_step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rd_en", 32'(in_rd_en), 32'h0);
      chk("bp_wr_en", 32'(out_wr_en), 32'h0);
      chk("bp_out_t", out_t, 32'h0001_8000);
      chk("bp_out_idx", 32'(out_idx), 32'd1);
      chk("bp_out_hit", 32'(out_hit), 32'd1);
      chk("bp_out_ray", 32'(out_ray), 32'(exp_ray));
      cyc_step();
    end
    out_full = 0;
    #1;
    chk("bp_release_wr_en", 32'(out_wr_en), 32'h1);
    chk("bp_release_rd_en", 32'(in_rd_en), 32'h0);
    cyc_step();
    chk("bp_resume_rd_en", 32'(in_rd_en), 32'h1);
    get_wr("bp_ray", w);
    chk("bp_ray_t", w.t, 32'h0001_8000);
    chk("bp_ray_idx", 32'(w.idx), 32'd1);
    chk("bp_ray_ray", 32'(w.ray), 32'(exp_ray));
    exp_ray++;
    get_wr("bp_next", w);
    chk("bp_next_t", w.t, 32'h0001_8000);
    chk("bp_next_ray", 32'(w.ray), 32'(exp_ray));
    chk("bp_next_latency", 32'(w.lat), 32'd1);
    exp_ray++;

    // three empty cycles between samples
    gap = 3;
    push(vec[0].s);
    get_wr("gap", w);
    chk("gap_t", w.t, 32'h0001_8000);
    chk("gap_idx", 32'(w.idx), 32'd1);
    chk("gap_hit", 32'(w.hit), 32'd1);
    chk("gap_ray", 32'(w.ray), 32'(exp_ray));
    chk("gap_latency", 32'(w.lat), 32'd1);
    exp_ray++;
    gap = 0;
    for (int n = 0; n < 20 && gap_left > 0; n++) cyc_step();

    // reset after two pops of a ray discards the partial result
    partial = '{32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0};
    sq.push_back(partial[0]);
    sq.push_back(partial[1]);
    for (int n = 0; n < 50 && sq.size() > 0; n++) cyc_step();
    cyc_step();
    reset = 1;
    cyc_step();
    push(vec[0].s);
    cyc_step();
    reset = 0;
    exp_ray = 0;
    get_wr("rst_mid", w);
    chk("rst_mid_t", w.t, 32'h0001_8000);
    chk("rst_mid_idx", 32'(w.idx), 32'd1);
    chk("rst_mid_ray", 32'(w.ray), 32'h0);
    exp_ray++;

    // sixteen more rays: the 17th since reset wraps the 4-bit ray id to 0
    for (int r = 1; r < 17; r++) begin
      push(vec[0].s);
      get_wr("wrap", w);
      chk($sformatf("wrap_ray%0d", r), 32'(w.ray), 32'(exp_ray));
      exp_ray++;
    end
    chk("wrap_ray17_zero", 32'(w.ray), 32'h0);
    chk("wrap_ray17_t", w.t, 32'h0001_8000);

    // NUM_TRI=1 instance: every pop emits, index always 0
    in_dout1 = 32'h0005_0000; in_empty1 = 0;
    #1;
    chk("nt1_rd_en", 32'(in_rd_en1), 32'h1);
    cyc_step();
    in_empty1 = 1;
    #1;
    chk("nt1_wr_en", 32'(out_wr_en1), 32'h1);
    chk("nt1_t", out_t1, 32'h0005_0000);
    chk("nt1_idx", 32'(out_idx1), 32'h0);
    chk("nt1_hit", 32'(out_hit1), 32'h1);
    chk("nt1_ray", 32'(out_ray1), 32'h0);
    cyc_step();
    in_dout1 = 32'h0; in_empty1 = 0;
    #1;
    chk("nt1_rd_en2", 32'(in_rd_en1), 32'h1);
    cyc_step();
    in_empty1 = 1;
    #1;
    chk("nt1_wr_en2", 32'(out_wr_en1), 32'h1);
    chk("nt1_miss_t", out_t1, 32'h7FFF_FFFF);
    chk("nt1_miss_hit", 32'(out_hit1), 32'h0);
    chk("nt1_ray2", 32'(out_ray1), 32'h1);
    repeat (3) cyc_step();

    chk("handshake_violations", 32'(viol), 32'h0);
    chk("write_count", 32'(n_wr), 32'(exp_wr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
